prince_sbox_layer_ti: RTL and testbench

PRINCE_SBOX_LAYER_TI -- requirements
Module: prince_sbox_layer_ti

---
 rtl/prince_sbox_layer_ti.sv | 199 +++++++++++++++++++
 tb/tb_prince_sbox_layer_ti.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prince_sbox_layer_ti.sv
// PRINCE S-box layer as a 4-share, degree-3 threshold implementation with changing-of-the-guards.
// Define PRINCE_INV_SBOX_EN to add the mode port and the inverse S-box.
module prince_sbox_layer_ti #(
    parameter int NIBBLES = 16,
    parameter int STAGES  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4*NIBBLES-1:0] in_s0,
    input  logic [4*NIBBLES-1:0] in_s1,
    input  logic [4*NIBBLES-1:0] in_s2,
    input  logic [4*NIBBLES-1:0] in_s3,
    input  logic [15:0]          rnd,
`ifdef PRINCE_INV_SBOX_EN
    input  logic                 mode,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*NIBBLES-1:0] out_s0,
    output logic [4*NIBBLES-1:0] out_s1,
    output logic [4*NIBBLES-1:0] out_s2,
    output logic [4*NIBBLES-1:0] out_s3,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int W = 4 * NIBBLES;

    // Algebraic normal form of each output bit: bit 16*b+m is the coefficient of monomial m.
    function automatic logic [63:0] anf_of(input logic [63:0] tbl);
        logic [63:0] r;
        logic [15:0] a;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            for (int x = 0; x < 16; x++) a[x] = tbl[4*x+b];
            for (int v = 0; v < 4; v++)
                for (int m = 0; m < 16; m++)
                    if (((m >> v) & 1) != 0) a[m] = a[m] ^ a[m ^ (1 << v)];
            r[16*b+:16] = a;
        end
        return r;
    endfunction

    // Each share-expanded term goes to the lowest share index it does not touch.
    function automatic logic [3:0] comp(input logic [63:0] anf, input int own,
                                        input logic [15:0] sh);
        logic [3:0] r;
        logic [3:0] used;
        logic       p;
        int         owner;
        int         idx [4];
        int         lim [4];
        r = '0;
        for (int b = 0; b < 4; b++)
            for (int m = 0; m < 16; m++)
                if (anf[16*b+m]) begin
                    for (int v = 0; v < 4; v++) lim[v] = (((m >> v) & 1) != 0) ? 4 : 1;
                    for (int a0 = 0; a0 < lim[0]; a0++)
                    for (int a1 = 0; a1 < lim[1]; a1++)
                    for (int a2 = 0; a2 < lim[2]; a2++)
                    for (int a3 = 0; a3 < lim[3]; a3++) begin
                        idx[0] = a0;
                        idx[1] = a1;
                        idx[2] = a2;
                        idx[3] = a3;
                        used = '0;
                        p = 1'b1;
                        for (int v = 0; v < 4; v++)
                            if (((m >> v) & 1) != 0) begin
                                used[idx[v][1:0]] = 1'b1;
                                p = p & sh[4*idx[v]+v];
                            end
                        owner = 0;
                        for (int k = 3; k >= 0; k--)
                            if (!used[k]) owner = k;
                        if (owner == own) r[b] = r[b] ^ p;
                    end
                end
        return r;
    endfunction

    localparam logic [63:0] SBOX_FWD = 64'h4D5E_0876_19CA_23FB;
    localparam logic [63:0] ANF_FWD  = anf_of(SBOX_FWD);
`ifdef PRINCE_INV_SBOX_EN
    localparam logic [63:0] SBOX_INV = 64'h1CE5_046A_98DF_237B;
    localparam logic [63:0] ANF_INV  = anf_of(SBOX_INV);
`endif

    logic [W-1:0] in_sh [4];
    logic [W-1:0] c_s   [4];
    logic [15:0]  c_rnd;
    logic         c_valid;
    logic         c_ready;
    logic [63:0]  anf_sel;
    logic [W-1:0] gk    [4];
    logic [W-1:0] f_s   [4];
    logic [W-1:0] o_s   [4];
`ifdef PRINCE_INV_SBOX_EN
    logic         c_mode;
`endif

    assign in_sh[0] = in_s0;
    assign in_sh[1] = in_s1;
    assign in_sh[2] = in_s2;
    assign in_sh[3] = in_s3;

    if (STAGES == 2 && NIBBLES >= 1 && NIBBLES <= 16) begin : g_front
        logic [W-1:0] p_s [4];
        logic [15:0]  p_rnd;
        logic         p_valid;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                p_valid <= 1'b0;
                p_rnd   <= '0;
                for (int i = 0; i < 4; i++) p_s[i] <= '0;
            end else begin
                if (in_ready) p_valid <= in_valid;
                if (in_valid && in_ready) begin
                    p_s   <= in_sh;
                    p_rnd <= rnd;
                end
            end
        end

`ifdef PRINCE_INV_SBOX_EN
        logic p_mode;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) p_mode <= 1'b0;
            else if (in_valid && in_ready) p_mode <= mode;
        end
        assign c_mode = p_mode;
`endif
        assign c_s      = p_s;
        assign c_rnd    = p_rnd;
        assign c_valid  = p_valid;
        assign in_ready = !p_valid || c_ready;
    end else if (STAGES == 1 && NIBBLES >= 1 && NIBBLES <= 16) begin : g_pass
`ifdef PRINCE_INV_SBOX_EN
        assign c_mode = mode;
`endif
        assign c_s      = in_sh;
        assign c_rnd    = rnd;
        assign c_valid  = in_valid;
        assign in_ready = c_ready;
    end else begin : g_bad
        $error("prince_sbox_layer_ti: STAGES must be 1 or 2 and NIBBLES 1..16");
    end

`ifdef PRINCE_INV_SBOX_EN
    assign anf_sel = c_mode ? ANF_INV : ANF_FWD;
`else
    assign anf_sel = ANF_FWD;
`endif

    // Lane 0 guards come from rnd, lane j>0 from lane j-1 of the same share.
    for (genvar k = 0; k < 4; k++) begin : g_guard
        if (NIBBLES == 1) begin : g_one
            assign gk[k] = c_rnd[4*k+:4];
        end else begin : g_many
            assign gk[k] = {c_s[k][W-5:0], c_rnd[4*k+:4]};
        end
    end

    always_comb begin
        logic [15:0] sh;
        logic [15:0] g;
        sh = '0;
        g  = '0;
        for (int k = 0; k < 4; k++) f_s[k] = '0;
        for (int j = 0; j < NIBBLES; j++) begin
            for (int k = 0; k < 4; k++) begin
                sh[4*k+:4] = c_s[k][4*j+:4];
                g[4*k+:4]  = gk[k][4*j+:4];
            end
            for (int i = 0; i < 4; i++)
                f_s[i][4*j+:4] = comp(anf_sel, i, sh & ~(16'hF << (4*i)))
                               ^ g[4*i+:4] ^ g[4*((i+1)%4)+:4];
        end
    end

    assign c_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            for (int i = 0; i < 4; i++) o_s[i] <= '0;
        end else begin
            if (c_ready) out_valid <= c_valid;
            if (c_valid && c_ready) o_s <= f_s;
        end
    end

    assign out_s0 = o_s[0];
    assign out_s1 = o_s[1];
    assign out_s2 = o_s[2];
    assign out_s3 = o_s[3];

endmodule

// File: tb/tb_prince_sbox_layer_ti.sv
// Bench for prince_sbox_layer_ti: one- and two-stage instances against a table-lookup S-box model.
// Build with PRINCE_INV_SBOX_EN to also exercise the inverse mode.
module tb_prince_sbox_layer_ti;

    localparam int N = 16;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_s0 = '0, in_s1 = '0, in_s2 = '0, in_s3 = '0;
    logic [15:0]  rnd = '0;
    logic         in_valid = 1'b0, out_ready = 1'b0, mode = 1'b0;
    logic         r1, v1, r2, v2;
    logic [W-1:0] a0, a1, a2, a3, b0, b1, b2, b3;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0]  q1[$];
    logic [63:0]  q2[$];
    logic         stall1 = 1'b0, stall2 = 1'b0;
    logic [255:0] held1, held2;

    int sb_fwd[16] = '{11, 15, 3, 2, 10, 12, 9, 1, 6, 7, 8, 0, 14, 5, 13, 4};
    int sb_inv[16] = '{11, 7, 3, 2, 15, 13, 8, 9, 10, 6, 4, 0, 5, 14, 12, 1};

    always #5 clk = ~clk;

    prince_sbox_layer_ti #(.NIBBLES(N), .STAGES(1)) u_s1 (
        .clk(clk), .rst(rst),
        .in_s0(in_s0), .in_s1(in_s1), .in_s2(in_s2), .in_s3(in_s3),
        .rnd(rnd),
`ifdef PRINCE_INV_SBOX_EN
        .mode(mode),
`endif
        .in_valid(in_valid), .in_ready(r1),
        .out_s0(a0), .out_s1(a1), .out_s2(a2), .out_s3(a3),
        .out_valid(v1), .out_ready(out_ready)
    );

    prince_sbox_layer_ti #(.NIBBLES(N), .STAGES(2)) u_s2 (
        .clk(clk), .rst(rst),
        .in_s0(in_s0), .in_s1(in_s1), .in_s2(in_s2), .in_s3(in_s3),
        .rnd(rnd),
`ifdef PRINCE_INV_SBOX_EN
        .mode(mode),
`endif
        .in_valid(in_valid), .in_ready(r2),
        .out_s0(b0), .out_s1(b1), .out_s2(b2), .out_s3(b3),
        .out_valid(v2), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] s0, s1, s2, s3, input logic md);
        logic [63:0] x, y;
        x = s0 ^ s1 ^ s2 ^ s3;
        y = '0;
        for (int j = 0; j < N; j++)
            y[4*j+:4] = 4'(md ? sb_inv[x[4*j+:4]] : sb_fwd[x[4*j+:4]]);
        return y;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] pick(input int i, input logic [63:0] s0, s1, s2, s3);
        case (i)
            0: return s0;
            1: return s1;
            2: return s2;
            default: return s3;
        endcase
    endfunction

    function automatic logic [3:0] gpair(input logic [15:0] r, input int i);
        return r[4*i+:4] ^ r[4*((i+1)%4)+:4];
    endfunction

    task automatic observe();
        if (stall1) begin
            chk("hold_v1", v1, 1);
            chk("hold_d1", {a3, a2, a1, a0}, held1);
        end
        if (v1 && out_ready) begin
            chk("pop_ok1", q1.size() != 0, 1);
            if (q1.size() != 0) chk("xor1", a0 ^ a1 ^ a2 ^ a3, q1.pop_front());
        end
        stall1 = v1 && !out_ready;
        held1  = {a3, a2, a1, a0};
        if (in_valid && r1) q1.push_back(model(in_s0, in_s1, in_s2, in_s3, mode));

        if (stall2) begin
            chk("hold_v2", v2, 1);
            chk("hold_d2", {b3, b2, b1, b0}, held2);
        end
        if (v2 && out_ready) begin
            chk("pop_ok2", q2.size() != 0, 1);
            if (q2.size() != 0) chk("xor2", b0 ^ b1 ^ b2 ^ b3, q2.pop_front());
        end
        stall2 = v2 && !out_ready;
        held2  = {b3, b2, b1, b0};
        if (in_valid && r2) q2.push_back(model(in_s0, in_s1, in_s2, in_s3, mode));
    endtask

    task automatic step(input logic iv, input logic ordy, input logic [63:0] s0, s1, s2, s3,
                        input logic [15:0] r, input logic md);
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        in_s0 = s0; in_s1 = s1; in_s2 = s2; in_s3 = s3;
        rnd  = r;
        mode = md;
        #1;
        observe();
    endtask

    task automatic shares_of(input logic [63:0] x, output logic [63:0] s0, s1, s2, s3);
        s0 = rand64();
        s1 = rand64();
        s2 = rand64();
        s3 = x ^ s0 ^ s1 ^ s2;
    endtask

    task automatic xfer(input logic [63:0] s0, s1, s2, s3, input logic [15:0] r, input logic md);
        step(1, 1, s0, s1, s2, s3, r, md);
        step(0, 1, s0, s1, s2, s3, r, md);
        step(0, 1, s0, s1, s2, s3, r, md);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 1, rand64(), rand64(), rand64(), rand64(), 16'($urandom), 1'b0);
    endtask

    initial begin
        logic [63:0]  s0, s1, s2, s3, t0, t1, t2, t3;
        logic [63:0]  c1, c2;
        logic [255:0] snap1, snap2;
        logic [15:0]  ra, rb;
        logic [3:0]   d;
        logic         md;
        int           i, j;

        #1;
        chk("rst_v1", v1, 0);
        chk("rst_v2", v2, 0);
        chk("rst_o1", {a3, a2, a1, a0}, 0);
        chk("rst_o2", {b3, b2, b1, b0}, 0);
        chk("rst_r1", r1, 1);
        chk("rst_r2", r2, 1);
        @(negedge clk);
        rst = 1'b0;

        // single-lane 5 -> C, latency 1 and 2
        step(1, 1, 64'h5, 64'h0, 64'h0, 64'h0, 16'h0000, 1'b0);
        step(0, 1, 64'h0, 64'h0, 64'h0, 64'h0, 16'h0000, 1'b0);
        chk("lat_v1", v1, 1);
        chk("lat_v2_early", v2, 0);
        chk("lane0_5", (a0 ^ a1 ^ a2 ^ a3) & 64'hF, 64'hC);
        step(0, 1, 64'h0, 64'h0, 64'h0, 64'h0, 16'h0000, 1'b0);
        chk("lat_v2", v2, 1);
        chk("lat_v1_done", v1, 0);
        chk("lane0_5_s2", (b0 ^ b1 ^ b2 ^ b3) & 64'hF, 64'hC);
        idle(2);

        // 100 back-to-back transfers of one state with fresh sharing and rnd
        for (int k = 0; k < 100; k++) begin
            shares_of(64'h0123456789ABCDEF, s0, s1, s2, s3);
            step(1, 1, s0, s1, s2, s3, 16'($urandom), 1'b0);
            chk("rdy1", r1, 1);
            chk("rdy2", r2, 1);
            if (k >= 1) chk("tput1", v1, 1);
            if (k >= 2) chk("tput2", v2, 1);
            if (k == 50) chk("state_b2b", a0 ^ a1 ^ a2 ^ a3, 64'hBF32AC916780E5D4);
        end
        idle(3);
        chk("drain1_b2b", q1.size(), 0);
        chk("drain2_b2b", q2.size(), 0);

        // output stall: both stages fill, nothing lost or duplicated on release
        for (int k = 0; k < 2; k++) begin
            shares_of(rand64(), s0, s1, s2, s3);
            step(1, 1, s0, s1, s2, s3, 16'($urandom), 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            shares_of(rand64(), s0, s1, s2, s3);
            step(1, 0, s0, s1, s2, s3, 16'($urandom), 1'b0);
        end
        chk("stall_r1", r1, 0);
        chk("stall_r2", r2, 0);
        chk("stall_v2", v2, 1);
        idle(4);
        chk("drain1_stall", q1.size(), 0);
        chk("drain2_stall", q2.size(), 0);

        // asynchronous reset while outputs are valid
        shares_of(rand64(), s0, s1, s2, s3);
        step(1, 1, s0, s1, s2, s3, 16'($urandom), 1'b0);
        shares_of(rand64(), s0, s1, s2, s3);
        step(1, 0, s0, s1, s2, s3, 16'($urandom), 1'b0);
        chk("pre_rst_v1", v1, 1);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_v1", v1, 0);
        chk("arst_v2", v2, 0);
        chk("arst_o1", {a3, a2, a1, a0}, 0);
        chk("arst_o2", {b3, b2, b1, b0}, 0);
        chk("arst_r1", r1, 1);
        chk("arst_r2", r2, 1);
        q1.delete();
        q2.delete();
        stall1 = 1'b0;
        stall2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        shares_of(64'h0, s0, s1, s2, s3);
        step(1, 1, s0, s1, s2, s3, 16'($urandom), 1'b0);
        step(0, 1, s0, s1, s2, s3, 16'($urandom), 1'b0);
        chk("post_rst1", a0 ^ a1 ^ a2 ^ a3, 64'hBBBBBBBBBBBBBBBB);
        step(0, 1, s0, s1, s2, s3, 16'($urandom), 1'b0);
        chk("post_rst2", b0 ^ b1 ^ b2 ^ b3, 64'hBBBBBBBBBBBBBBBB);
        idle(1);

        // share registers hold while idle
        snap1 = {a3, a2, a1, a0};
        snap2 = {b3, b2, b1, b0};
        for (int k = 0; k < 3; k++)
            step(0, 1'($urandom), rand64(), rand64(), rand64(), rand64(), 16'($urandom), 1'b0);
        chk("idle_hold1", {a3, a2, a1, a0}, snap1);
        chk("idle_hold2", {b3, b2, b1, b0}, snap2);
        out_ready = 1'b1;
        idle(2);

        // output share i must not depend on input share i of its lane
        for (int k = 0; k < 8; k++) begin
            i  = k % 4;
            j  = $urandom_range(0, N - 1);
            ra = 16'($urandom);
            shares_of(rand64(), s0, s1, s2, s3);
            xfer(s0, s1, s2, s3, ra, 1'b0);
            c1 = pick(i, a0, a1, a2, a3);
            c2 = pick(i, b0, b1, b2, b3);
            d  = 4'($urandom_range(1, 15));
            t0 = s0; t1 = s1; t2 = s2; t3 = s3;
            case (i)
                0: t0[4*j+:4] = t0[4*j+:4] ^ d;
                1: t1[4*j+:4] = t1[4*j+:4] ^ d;
                2: t2[4*j+:4] = t2[4*j+:4] ^ d;
                default: t3[4*j+:4] = t3[4*j+:4] ^ d;
            endcase
            xfer(t0, t1, t2, t3, ra, 1'b0);
            chk("probe1", 256'(pick(i, a0, a1, a2, a3) >> (4*j)) & 256'hF, 256'(c1 >> (4*j)) & 256'hF);
            chk("probe2", 256'(pick(i, b0, b1, b2, b3) >> (4*j)) & 256'hF, 256'(c2 >> (4*j)) & 256'hF);
        end

        // lane-0 guards: changing rnd shifts share i by G[i]^G[i+1]
        for (int k = 0; k < 3; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            shares_of(rand64(), s0, s1, s2, s3);
            xfer(s0, s1, s2, s3, ra, 1'b0);
            snap1 = {a3, a2, a1, a0};
            xfer(s0, s1, s2, s3, rb, 1'b0);
            for (int m = 0; m < 4; m++)
                chk("guard", 256'(pick(m, a0, a1, a2, a3) ^ snap1[64*m+:64]) & 256'hF,
                    256'(gpair(ra, m) ^ gpair(rb, m)));
            chk("guard_upper", {a3[63:4], a2[63:4], a1[63:4], a0[63:4]},
                {snap1[255:196], snap1[191:132], snap1[127:68], snap1[63:4]});
        end

`ifdef PRINCE_INV_SBOX_EN
        shares_of(64'hCCCCCCCCCCCCCCCC, s0, s1, s2, s3);
        xfer(s0, s1, s2, s3, 16'($urandom), 1'b1);
        chk("inv_c1", a0 ^ a1 ^ a2 ^ a3, 64'h5555555555555555);
        chk("inv_c2", b0 ^ b1 ^ b2 ^ b3, 64'h5555555555555555);
        for (int k = 0; k < 20; k++) begin
            shares_of(rand64(), s0, s1, s2, s3);
            step(1, 1, s0, s1, s2, s3, 16'($urandom), 1'(k & 1));
        end
        idle(3);
`endif

        // random handshake traffic
        for (int k = 0; k < 300; k++) begin
            shares_of(rand64(), s0, s1, s2, s3);
`ifdef PRINCE_INV_SBOX_EN
            md = 1'($urandom);
`else
            md = 1'b0;
`endif
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 s0, s1, s2, s3, 16'($urandom), md);
        end
        idle(4);
        chk("drain1_rand", q1.size(), 0);
        chk("drain2_rand", q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
